// File: rtl/jtag_dma_controller_if.sv
// System bus signal bundle between the JTAG DMA engine (master) and the bus fabric (slave).
interface jtag_dma_controller_if;
  logic        bus_request;
  logic        bus_grant;
  logic        bus_begin_transaction;
  logic [31:0] bus_address;
  logic [7:0]  bus_burst_size;
  logic        bus_read_n_write;
  logic [3:0]  bus_byte_enables;
  logic [31:0] bus_data_out;
  logic        bus_data_valid_out;
  logic        bus_busy_in;
  logic        bus_end_transaction_out;
  logic [31:0] bus_data_in;
  logic        bus_data_valid_in;
  logic        bus_end_transaction_in;
  logic        bus_error_in;

  modport master (
    output bus_request, bus_begin_transaction, bus_address, bus_burst_size,
           bus_read_n_write, bus_byte_enables, bus_data_out, bus_data_valid_out,
           bus_end_transaction_out,
    input  bus_grant, bus_busy_in, bus_data_in, bus_data_valid_in,
           bus_end_transaction_in, bus_error_in
  );

  modport slave (
    input  bus_request, bus_begin_transaction, bus_address, bus_burst_size,
           bus_read_n_write, bus_byte_enables, bus_data_out, bus_data_valid_out,
           bus_end_transaction_out,
    output bus_grant, bus_busy_in, bus_data_in, bus_data_valid_in,
           bus_end_transaction_in, bus_error_in
  );
endinterface

// File: rtl/jtag_dma_controller.sv
// DMA engine behind JTAG chain 1: moves blocks of words between the
// ping-pong buffer and the system bus in bursts, reporting busy/count/error.
module jtag_dma_controller #(
  parameter int BUF_AW     = 9,
  parameter int WORD_BYTES = 4
) (
  input  logic              system_clk,
  input  logic              n_reset,
  input  logic              launch_write,
  input  logic              launch_read,
  input  logic [31:0]       dma_address,
  input  logic [3:0]        dma_byte_enable,
  input  logic [7:0]        dma_burst_size,
  input  logic [7:0]        dma_block_size,
  output logic              dma_busy,
  output logic [7:0]        dma_block_size_out,
  output logic              dma_error,
  output logic [BUF_AW-1:0] buf_address,
  output logic              buf_write_enable,
  output logic [31:0]       buf_data_in,
  input  logic [31:0]       buf_data_out,
  jtag_dma_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_BEGIN, S_WRITE_DATA, S_WRITE_END, S_READ_DATA, S_NEXT, S_DONE
  } state_t;

  state_t      state, state_next;
  logic [31:0] start_addr;
  logic [3:0]  byte_en;
  logic [7:0]  burst_size;
  logic        is_read;
  logic [7:0]  index;       // words completed so far, also the buffer word index
  logic [7:0]  remaining;   // words still to move
  logic [7:0]  burst_len;   // beats in the current burst
  logic [7:0]  beats;       // beats completed in the current burst

  logic        launch;
  logic        abort;
  logic [8:0]  max_beats;
  logic [7:0]  cur_len;
  logic        write_accept;
  logic        read_take;
  logic        last_write;

  assign launch       = launch_write | launch_read;
  assign abort        = (state != S_IDLE) && bus.bus_error_in;
  assign max_beats    = {1'b0, burst_size} + 9'd1;
  // remaining is at most 255, so whichever side is chosen fits in 8 bits
  assign cur_len      = ({1'b0, remaining} < max_beats) ? remaining : max_beats[7:0];
  assign write_accept = (state == S_WRITE_DATA) && !bus.bus_busy_in && !bus.bus_error_in;
  assign read_take    = (state == S_READ_DATA) && bus.bus_data_valid_in &&
                        (beats < burst_len) && !bus.bus_error_in;
  assign last_write   = write_accept && ((beats + 8'd1) == burst_len);

  // State register
  always_ff @(posedge system_clk or negedge n_reset) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; a bus error sends any active state to DONE
  always_comb begin
    state_next = state;
    if (abort && state != S_DONE) begin
      state_next = S_DONE;
    end else begin
      case (state)
        S_IDLE:       if (launch) state_next = (dma_block_size == 8'd0) ? S_DONE : S_REQUEST;
                      else        state_next = S_IDLE;
        S_REQUEST:    state_next = bus.bus_grant ? S_BEGIN : S_REQUEST;
        S_BEGIN:      state_next = is_read ? S_READ_DATA : S_WRITE_DATA;
        S_WRITE_DATA: state_next = last_write ? S_WRITE_END : S_WRITE_DATA;
        S_WRITE_END:  state_next = S_NEXT;
        S_READ_DATA:  state_next = bus.bus_end_transaction_in ? S_NEXT : S_READ_DATA;
        S_NEXT:       state_next = (remaining != 8'd0) ? S_REQUEST : S_DONE;
        S_DONE:       state_next = S_IDLE;
        default:      state_next = S_IDLE;
      endcase
    end
  end

  // Operation context, word/beat counters, sticky error and reported count
  always_ff @(posedge system_clk or negedge n_reset) begin
    if (!n_reset) begin
      start_addr         <= 32'd0;
      byte_en            <= 4'd0;
      burst_size         <= 8'd0;
      is_read            <= 1'b0;
      index              <= 8'd0;
      remaining          <= 8'd0;
      burst_len          <= 8'd0;
      beats              <= 8'd0;
      dma_error          <= 1'b0;
      dma_block_size_out <= 8'd0;
    end else begin
      if (state == S_IDLE && launch) begin
        start_addr <= dma_address;
        byte_en    <= dma_byte_enable;
        burst_size <= dma_burst_size;
        is_read    <= !launch_write;   // write wins when both pulse together
        index      <= 8'd0;
        remaining  <= dma_block_size;
        dma_error  <= 1'b0;
      end
      if (state == S_BEGIN) begin
        burst_len <= cur_len;
        beats     <= 8'd0;
      end
      if (write_accept || read_take) begin
        index     <= index + 8'd1;
        remaining <= remaining - 8'd1;
        beats     <= beats + 8'd1;
      end
      if (abort) dma_error <= 1'b1;
      if (state == S_DONE) dma_block_size_out <= index;
    end
  end

  // Output decode from state, with bus error dropping request and write valid
  always_comb begin
    dma_busy                    = (state != S_IDLE);
    buf_address                 = {BUF_AW{1'b0}};
    buf_write_enable            = 1'b0;
    buf_data_in                 = 32'd0;
    bus.bus_request             = 1'b0;
    bus.bus_begin_transaction   = 1'b0;
    bus.bus_address             = 32'd0;
    bus.bus_burst_size          = 8'd0;
    bus.bus_read_n_write        = 1'b0;
    bus.bus_byte_enables        = 4'd0;
    bus.bus_data_out            = 32'd0;
    bus.bus_data_valid_out      = 1'b0;
    bus.bus_end_transaction_out = 1'b0;
    case (state)
      S_REQUEST: bus.bus_request = 1'b1;
      S_BEGIN: begin
        bus.bus_request           = 1'b1;
        bus.bus_begin_transaction = 1'b1;
        bus.bus_address           = start_addr + (32'(index) * 32'(WORD_BYTES));
        bus.bus_burst_size        = cur_len - 8'd1;
        bus.bus_read_n_write      = is_read;
        bus.bus_byte_enables      = byte_en;
        // prefetch the first write word so it is on buf_data_out next cycle
        buf_address               = BUF_AW'(index);
      end
      S_WRITE_DATA: begin
        bus.bus_request        = 1'b1;
        bus.bus_data_out       = buf_data_out;
        bus.bus_data_valid_out = 1'b1;
        // advance the read address only when the current beat is taken
        buf_address            = BUF_AW'({1'b0, index} + {8'd0, write_accept});
      end
      S_WRITE_END: bus.bus_end_transaction_out = 1'b1;
      S_READ_DATA: begin
        bus.bus_request  = 1'b1;
        buf_address      = BUF_AW'(index);
        buf_write_enable = read_take;
        buf_data_in      = bus.bus_data_in;
      end
      default: buf_address = {BUF_AW{1'b0}};
    endcase
    if (abort) begin
      bus.bus_request        = 1'b0;
      bus.bus_data_valid_out = 1'b0;
    end else begin
      bus.bus_request        = bus.bus_request;
    end
  end

endmodule

// File: tb/tb_jtag_dma_controller.sv
// Self-checking bench for jtag_dma_controller: buffer RAM model, bus slave
// responder and a transaction-level reference model of the expected bursts.
module tb_jtag_dma_controller;
  localparam int BUF_AW = 9;

  logic              system_clk = 1'b0;
  logic              n_reset;
  logic              launch_write, launch_read;
  logic [31:0]       dma_address;
  logic [3:0]        dma_byte_enable;
  logic [7:0]        dma_burst_size, dma_block_size;
  logic              dma_busy;
  logic [7:0]        dma_block_size_out;
  logic              dma_error;
  logic [BUF_AW-1:0] buf_address;
  logic              buf_write_enable;
  logic [31:0]       buf_data_in, buf_data_out;

  jtag_dma_controller_if bus();

  jtag_dma_controller #(.BUF_AW(BUF_AW), .WORD_BYTES(4)) dut (
    .system_clk(system_clk), .n_reset(n_reset),
    .launch_write(launch_write), .launch_read(launch_read),
    .dma_address(dma_address), .dma_byte_enable(dma_byte_enable),
    .dma_burst_size(dma_burst_size), .dma_block_size(dma_block_size),
    .dma_busy(dma_busy), .dma_block_size_out(dma_block_size_out), .dma_error(dma_error),
    .buf_address(buf_address), .buf_write_enable(buf_write_enable),
    .buf_data_in(buf_data_in), .buf_data_out(buf_data_out),
    .bus(bus)
  );

  always #5 system_clk = ~system_clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  size;
    logic        rnw;
    logic [3:0]  be;
  } hdr_t;

  int checks = 0;
  int failures = 0;

  // buffer RAM: synchronous read, one cycle latency
  logic [31:0] buf_mem [0:(1<<BUF_AW)-1];
  logic [31:0] pre [0:255];
  always @(posedge system_clk) begin
    if (buf_write_enable) buf_mem[buf_address] <= buf_data_in;
    buf_data_out <= buf_mem[buf_address];
  end

  // slave configuration and logs
  hdr_t        hdr_q[$], exp_q[$];
  logic [31:0] wr_q[$], rd_data_q[$];
  int          end_cnt, beat_num, rd_left, extra_left, stall_cnt;
  int          stall_pct = 0, gap_pct = 0, short_beats = 0, extra_beats = 0;
  int          err_beat = 0, stall_at = -1, stall_len = 0;
  bit          rd_active = 0, wr_active = 0, short_used = 0, prev_stall = 0;
  logic [31:0] prev_stall_data;
  hdr_t        rh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bus slave: drive inputs at negedge, then sample what the DUT sees at the next posedge
  always @(negedge system_clk) begin
    bus.bus_grant = 1'b0; bus.bus_busy_in = 1'b0; bus.bus_data_in = 32'd0;
    bus.bus_data_valid_in = 1'b0; bus.bus_end_transaction_in = 1'b0; bus.bus_error_in = 1'b0;
    if (!n_reset) begin
      rd_active = 0; wr_active = 0; prev_stall = 0;
    end else begin
      bus.bus_grant = bus.bus_request && ($urandom_range(0, 2) != 0);
      if (bus.bus_begin_transaction) begin
        rh.addr = bus.bus_address; rh.size = bus.bus_burst_size;
        rh.rnw = bus.bus_read_n_write; rh.be = bus.bus_byte_enables;
        hdr_q.push_back(rh);
        if (bus.bus_read_n_write) begin
          rd_active = 1;
          rd_left = int'(bus.bus_burst_size) + 1;
          extra_left = extra_beats;
          if (short_beats > 0 && !short_used && short_beats < rd_left) begin
            rd_left = short_beats; short_used = 1; extra_left = 0;
          end
        end else begin
          wr_active = 1;
        end
      end else if (rd_active) begin
        if (int'($urandom_range(0, 99)) >= gap_pct) begin
          if (rd_left > 0 || extra_left > 0) begin
            beat_num++;
            bus.bus_data_valid_in = 1'b1;
            bus.bus_data_in = $urandom;
            if (beat_num == err_beat) begin
              bus.bus_error_in = 1'b1; rd_active = 0;
            end else if (rd_left > 0) begin
              rd_data_q.push_back(bus.bus_data_in); rd_left--;
            end else begin
              extra_left--;
            end
          end else begin
            bus.bus_end_transaction_in = 1'b1; rd_active = 0;
          end
        end
      end else if (wr_active) begin
        if (wr_q.size() == stall_at && stall_cnt < stall_len) begin
          bus.bus_busy_in = 1'b1; stall_cnt++;
        end else begin
          bus.bus_busy_in = (int'($urandom_range(0, 99)) < stall_pct);
        end
      end
      #1;
      if (bus.bus_data_valid_out) begin
        if (prev_stall) chk("stall_hold", bus.bus_data_out, prev_stall_data);
        if (!bus.bus_busy_in) begin
          wr_q.push_back(bus.bus_data_out); prev_stall = 0;
        end else begin
          prev_stall = 1; prev_stall_data = bus.bus_data_out;
        end
      end
      if (bus.bus_end_transaction_out) begin
        end_cnt++; wr_active = 0; prev_stall = 0;
      end
    end
  end

  // transaction-level expectation: burst headers, words completed, error flag
  task automatic model(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                       input int bsz, input int blk, output int done, output bit err);
    int len, got, seen;
    bit short_avail;
    hdr_t h;
    exp_q.delete(); done = 0; err = 0; seen = 0; short_avail = (short_beats > 0);
    while (done < blk && !err) begin
      len = (blk - done < bsz + 1) ? blk - done : bsz + 1;
      h.addr = addr + 32'(4 * done); h.size = 8'(len - 1); h.rnw = !wr; h.be = be;
      exp_q.push_back(h);
      got = len;
      if (!wr && short_avail && short_beats < len) begin
        got = short_beats; short_avail = 0;
      end
      if (!wr && err_beat > 0 && seen + got >= err_beat) begin
        done += err_beat - 1 - seen; err = 1;
      end else begin
        done += got;
        seen += got + ((!wr && got == len) ? extra_beats : 0);
      end
    end
  endtask

  task automatic preload(input int n, input bit fixed);
    for (int i = 0; i < 256; i++) begin
      pre[i] = (fixed && i < n) ? 32'hA0 + 32'(i) : $urandom;
      buf_mem[i] = pre[i];
    end
  endtask

  task automatic run_op(input string tag, input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [3:0] be, input logic [7:0] bsz, input logic [7:0] blk,
                        input bit poke, output int busy_n);
    hdr_q.delete(); wr_q.delete(); rd_data_q.delete();
    end_cnt = 0; beat_num = 0; short_used = 0; stall_cnt = 0;
    @(negedge system_clk);
    launch_write = wr; launch_read = rd;
    dma_address = addr; dma_byte_enable = be; dma_burst_size = bsz; dma_block_size = blk;
    @(negedge system_clk);
    launch_write = 1'b0; launch_read = 1'b0;
    dma_address = $urandom; dma_byte_enable = 4'($urandom);
    dma_burst_size = 8'($urandom); dma_block_size = 8'($urandom);
    chk({tag, ":busy_rise"}, 32'(dma_busy), 32'd1);
    chk({tag, ":err_clr"}, 32'(dma_error), 32'd0);
    busy_n = 1;
    while (dma_busy && busy_n < 3000) begin
      @(negedge system_clk);
      if (poke && busy_n == 3) launch_read = 1'b1;
      else launch_read = 1'b0;
      if (dma_busy) busy_n++;
    end
    launch_read = 1'b0;
    chk({tag, ":done_in_time"}, 32'(dma_busy), 32'd0);
    repeat (2) @(negedge system_clk);
  endtask

  task automatic verify(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input int bsz, input int blk);
    int done, n;
    bit err;
    model(wr, addr, be, bsz, blk, done, err);
    chk({tag, ":n_hdr"}, 32'(hdr_q.size()), 32'(exp_q.size()));
    n = (hdr_q.size() < exp_q.size()) ? hdr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s:hdr%0d_addr", tag, i), hdr_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s:hdr%0d_size", tag, i), 32'(hdr_q[i].size), 32'(exp_q[i].size));
      chk($sformatf("%s:hdr%0d_rnw", tag, i), 32'(hdr_q[i].rnw), 32'(exp_q[i].rnw));
      chk($sformatf("%s:hdr%0d_be", tag, i), 32'(hdr_q[i].be), 32'(exp_q[i].be));
    end
    chk({tag, ":count"}, 32'(dma_block_size_out), 32'(done));
    chk({tag, ":error"}, 32'(dma_error), 32'(err));
    if (wr) begin
      chk({tag, ":n_beats"}, 32'(wr_q.size()), 32'(done));
      n = (wr_q.size() < done) ? wr_q.size() : done;
      for (int i = 0; i < n; i++) chk($sformatf("%s:beat%0d", tag, i), wr_q[i], pre[i]);
      chk({tag, ":n_end"}, 32'(end_cnt), 32'(exp_q.size()));
    end else begin
      chk({tag, ":n_rdata"}, 32'(rd_data_q.size()), 32'(done));
      n = (rd_data_q.size() < done) ? rd_data_q.size() : done;
      for (int i = 0; i < n; i++) chk($sformatf("%s:buf%0d", tag, i), buf_mem[i], rd_data_q[i]);
    end
  endtask

  initial begin
    int busy_n, k, ends_at_reset;
    bit wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [7:0]  bsz, blk;

    n_reset = 1'b0; launch_write = 1'b0; launch_read = 1'b0;
    dma_address = 32'd0; dma_byte_enable = 4'd0; dma_burst_size = 8'd0; dma_block_size = 8'd0;
    bus.bus_grant = 1'b0; bus.bus_busy_in = 1'b0; bus.bus_data_in = 32'd0;
    bus.bus_data_valid_in = 1'b0; bus.bus_end_transaction_in = 1'b0; bus.bus_error_in = 1'b0;
    preload(0, 0);
    #12;
    chk("rst:busy", 32'(dma_busy), 32'd0);
    chk("rst:count", 32'(dma_block_size_out), 32'd0);
    chk("rst:error", 32'(dma_error), 32'd0);
    chk("rst:request", 32'(bus.bus_request), 32'd0);
    chk("rst:buf_we", 32'(buf_write_enable), 32'd0);
    @(negedge system_clk); n_reset = 1'b1;
    repeat (2) @(negedge system_clk);

    // write, block 5, bursts of 2 at 0x100
    preload(5, 1);
    run_op("wr5", 1, 0, 32'h100, 4'hF, 8'd1, 8'd5, 0, busy_n);
    verify("wr5", 1, 32'h100, 4'hF, 1, 5);
    chk("wr5:third_addr", hdr_q.size() > 2 ? hdr_q[2].addr : 32'd0, 32'h110);

    // read, block 4, single burst
    run_op("rd4", 0, 1, 32'h2000, 4'h3, 8'd7, 8'd4, 0, busy_n);
    verify("rd4", 0, 32'h2000, 4'h3, 7, 4);

    // write with a 3-cycle stall on the second beat
    preload(0, 0);
    stall_at = 1; stall_len = 3;
    run_op("wrstall", 1, 0, 32'h400, 4'hC, 8'd3, 8'd6, 0, busy_n);
    verify("wrstall", 1, 32'h400, 4'hC, 3, 6);
    stall_at = -1; stall_len = 0;

    // bus error on beat 3 of an 8-word read
    err_beat = 3;
    run_op("rderr", 0, 1, 32'h800, 4'hF, 8'd7, 8'd8, 0, busy_n);
    verify("rderr", 0, 32'h800, 4'hF, 7, 8);
    chk("rderr:count_const", 32'(dma_block_size_out), 32'd2);
    err_beat = 0;

    // next launch clears the error; also tests simultaneous launches and a launch while busy
    preload(0, 0);
    run_op("both", 1, 1, 32'h3000, 4'h5, 8'd2, 8'd7, 1, busy_n);
    verify("both", 1, 32'h3000, 4'h5, 2, 7);
    repeat (6) @(negedge system_clk);
    chk("both:idle_after", 32'(dma_busy), 32'd0);
    chk("both:no_extra_hdr", 32'(hdr_q.size()), 32'(exp_q.size()));

    // block size 0: one busy cycle, no bus activity
    run_op("blk0", 1, 0, 32'h40, 4'hF, 8'd3, 8'd0, 0, busy_n);
    verify("blk0", 1, 32'h40, 4'hF, 3, 0);
    chk("blk0:busy_len", 32'(busy_n), 32'd1);

    // randomized transactions with stalls, gaps, short and over-long read bursts
    for (int t = 0; t < 8; t++) begin
      wr = 1'($urandom_range(0, 1));
      addr = (t == 3) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      be = 4'($urandom);
      bsz = 8'($urandom_range(0, 9));
      blk = 8'($urandom_range(1, 24));
      stall_pct = $urandom_range(0, 40);
      gap_pct = $urandom_range(0, 40);
      short_beats = wr ? 0 : $urandom_range(0, 2);
      extra_beats = wr ? 0 : $urandom_range(0, 2);
      preload(0, 0);
      run_op($sformatf("rnd%0d", t), wr, !wr, addr, be, bsz, blk, 0, busy_n);
      verify($sformatf("rnd%0d", t), wr, addr, be, int'(bsz), int'(blk));
    end
    stall_pct = 0; gap_pct = 0; short_beats = 0; extra_beats = 0;

    // reset in the middle of a long write
    stall_pct = 50;
    hdr_q.delete(); wr_q.delete(); end_cnt = 0; stall_cnt = 0;
    @(negedge system_clk);
    launch_write = 1'b1; dma_address = 32'h5000; dma_byte_enable = 4'hF;
    dma_burst_size = 8'd3; dma_block_size = 8'd40;
    @(negedge system_clk);
    launch_write = 1'b0;
    k = 0;
    while (hdr_q.size() < 2 && k < 2000) begin
      @(negedge system_clk); k++;
    end
    chk("rstmid:reached_burst2", 32'(hdr_q.size() >= 2), 32'd1);
    #2;
    ends_at_reset = end_cnt;
    n_reset = 1'b0;
    #1;
    chk("rstmid:busy", 32'(dma_busy), 32'd0);
    chk("rstmid:request", 32'(bus.bus_request), 32'd0);
    chk("rstmid:begin", 32'(bus.bus_begin_transaction), 32'd0);
    chk("rstmid:valid", 32'(bus.bus_data_valid_out), 32'd0);
    chk("rstmid:end", 32'(bus.bus_end_transaction_out), 32'd0);
    chk("rstmid:data", bus.bus_data_out, 32'd0);
    chk("rstmid:count", 32'(dma_block_size_out), 32'd0);
    chk("rstmid:buf_addr", 32'(buf_address), 32'd0);
    chk("rstmid:buf_we", 32'(buf_write_enable), 32'd0);
    repeat (4) @(negedge system_clk);
    chk("rstmid:no_end_strobe", 32'(end_cnt), 32'(ends_at_reset));
    n_reset = 1'b1;
    repeat (4) @(negedge system_clk);
    chk("rstmid:stays_idle", 32'(dma_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_dma_controller.md
Name: jtag_dma_controller

Overview:
- System-clock DMA engine directly downstream of the JTAG chain-1 command stage.
- Consumes the synchronised launch pulses, address, byte enables, burst size and block size.
- Moves words between the DMA-side port of the ping-pong buffer and the system bus as a burst-capable bus master.
- Returns the received word count and a busy flag to chain 1.

Parameters:
BUF_AW, 9, ping-pong buffer address width; word index is zero-extended into it.
WORD_BYTES, 4, bus address increment per word.

Ports:
system_clk  in  1  system clock; all logic on rising edge
n_reset  in  1  asynchronous active-low reset
launch_write  in  1  one-cycle pulse: copy buffer words 0..block_size-1 to memory
launch_read  in  1  one-cycle pulse: fill buffer words 0..block_size-1 from memory
dma_address  in  32  start byte address, sampled at launch
dma_byte_enable  in  4  byte enables, sampled at launch
dma_burst_size  in  8  beats per burst minus 1, sampled at launch
dma_block_size  in  8  total words, sampled at launch
dma_busy  out  1  high from the cycle after an accepted launch until return to IDLE
dma_block_size_out  out  8  words written to the buffer by the last read; after a write, equals words sent
dma_error  out  1  sticky bus error of the last operation, cleared by next accepted launch
buf_address  out  BUF_AW  buffer word index
buf_write_enable  out  1  buffer write strobe
buf_data_in  out  32  buffer write data
buf_data_out  in  32  buffer read data, synchronous, 1-cycle latency
bus_request  out  1  bus request
bus_grant  in  1  bus grant
bus_begin_transaction  out  1  one-cycle burst header strobe
bus_address  out  32  burst start address, valid with begin
bus_burst_size  out  8  beats minus 1, valid with begin
bus_read_n_write  out  1  1 = read burst, valid with begin
bus_byte_enables  out  4  valid with begin
bus_data_out  out  32  write beat data
bus_data_valid_out  out  1  write beat valid
bus_busy_in  in  1  slave stall; beat accepted when valid_out and not busy_in
bus_end_transaction_out  out  1  one-cycle strobe after last write beat
bus_data_in  in  32  read beat data
bus_data_valid_in  in  1  read beat valid
bus_end_transaction_in  in  1  slave ends read burst
bus_error_in  in  1  slave error; aborts the operation

Behaviour:
- Reset:
  - All outputs 0 and state IDLE.
  - dma_block_size_out = 0.
  - Reset mid-operation abandons the transfer immediately; no end strobe is issued.
- Launch:
  - Accepted only in IDLE; launches while busy are ignored.
  - launch_write and launch_read in the same cycle: write wins and the read is dropped.
  - On accept: latch all inputs, clear dma_error, word index = 0, remaining = block_size.
- Block size 0: IDLE -> DONE -> IDLE with no bus activity; dma_block_size_out = 0; dma_busy high for 1 cycle.
- Burst length = min(remaining, burst_size+1), always in 1..255.
  - Each burst address = start + WORD_BYTES * words done, 32-bit wrap-around.
- FSM states and transitions:
  - IDLE -> REQUEST on launch (or -> DONE if block size is 0).
  - REQUEST: bus_request held high until bus_grant -> BEGIN.
  - BEGIN: one cycle with begin_transaction and header; bus_request stays high. Write -> WRITE_DATA; read -> READ_DATA.
    - For writes, buf_address = current index here, so data is ready in the first WRITE_DATA cycle.
  - WRITE_DATA:
    - bus_data_out = buf_data_out and bus_data_valid_out = 1.
    - buf_address = index + (accepted this cycle), so the next word arrives on the next cycle.
    - On the last accepted beat -> WRITE_END.
  - WRITE_END: end_transaction_out for 1 cycle, drop request -> NEXT.
  - READ_DATA:
    - Each data_valid_in writes bus_data_in to buf_address = index with buf_write_enable for that cycle, then increments index.
    - Beats beyond the burst length are discarded.
    - end_transaction_in -> NEXT.
  - NEXT: remaining > 0 -> REQUEST; else -> DONE.
  - DONE: dma_block_size_out = index; -> IDLE.
- Error: bus_error_in in any non-IDLE state sets dma_error, drops request and valid -> DONE; dma_block_size_out = words completed.
- Short read: if the slave ends a burst early, remaining is reduced by beats actually received only.

Test Plan:
- Write, block 5, burst_size 1, address 0x100, buffer preloaded with 0xA0..0xA4 -> three bursts at 0x100/0x108/0x110 with lengths 2,2,1; beats A0..A4 in order; three end strobes; dma_block_size_out = 5.
- Read, block 4, burst_size 7, address 0x2000 -> one burst with header burst_size 3 and read_n_write = 1; buffer words 0..3 = slave data; dma_block_size_out = 4; busy drops after DONE.
- Write with bus_busy_in stalls of 3 cycles on beat 2 -> beat 2 data and valid are held stable; no duplicated or skipped word.
- bus_error_in on beat 3 of an 8-word read -> dma_error = 1, dma_block_size_out = 2, return to IDLE; the next launch clears dma_error.
- Simultaneous launch_write and launch_read, then a launch during busy -> only the write is executed; the second launch has no effect.
- Block size 0 launch, then n_reset asserted mid-burst on a later transfer -> no bus activity, and all outputs go to 0 asynchronously.
